disp_hex_demux: RTL and testbench
=================================

// Module: disp_hex_demux
// PURPOSE
//  Receive-side decoder for the 4-digit multiplexed 7-seg bus (an/sseg) driven by the display mux.
//  Samples each digit dwell once it has settled, decodes active-low segment patterns back to hex nibbles
//  and assembles full 4-digit frames. Sits beside the display unit in loopback/self-check builds,
//  so the displayed PC/data byte can be compared with processor state.
// PARAMETERS
//  SETTLE   4        cycles an/sseg must be unchanged before a dwell is sampled (>=1)
//  TIMEOUT  1048576  cycles without a completed frame before timeout asserts (>=16)
// PORTS
//  clk          in   1   system clock (same 50 MHz clock as the display mux)
//  reset        in   1   asynchronous, active-high reset
//  an           in   4   anode enables, active low, one-hot-low when a digit is lit
//  sseg         in   8   segments, active low: [7]=dp, [6:0]={a,b,c,d,e,f,g}
//  hex3..hex0   out  4   decoded nibble per digit of last complete frame (an[3]..an[0])
//  dp_out       out  4   dp state per digit of last frame, 1 = dp lit
//  frame_valid  out  1   one-cycle pulse when hex*/dp_out update
//  digit_err    out  1   sticky: a sampled pattern matched no hex code
//  scan_err     out  1   sticky: settled an was neither 4'b1111 nor one-hot-low
//  timeout      out  1   level: TIMEOUT cycles elapsed since last frame_valid or reset
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): all outputs 0, seen mask 0, counters 0, state WAIT.
//  Input regs: an/sseg registered once (an_q/sseg_q); all decisions use registered values.
//  Stability counter stab: cleared when {an,sseg} != {an_q,sseg_q}, else increments, saturates at SETTLE.
//  FSM:
//   WAIT   : stab==SETTLE-1 and an_q one-hot-low -> SAMPLE; settled an_q==4'b1111 -> stay (blank);
//            settled an_q other pattern -> set scan_err, stay.
//   SAMPLE : single cycle; capture digit, go HOLD.
//   HOLD   : any change of an/sseg -> WAIT; otherwise stay (at most one capture per dwell).
//  Decode table sseg_q[6:0] (hex) -> nibble: 01->0 4F->1 12->2 06->3 4C->4 24->5 20->6 0F->7
//            00->8 04->9 08->A 60->B 31->C 42->D 30->E 38->F. No match: nibble 0, set digit_err.
//  Capture: shadow[i] <= nibble, dps[i] <= ~sseg_q[7], seen[i] <= 1 for the active index i.
//  Frame: when seen (including the bit set this cycle) == 4'b1111, on the next cycle copy shadow->hex*,
//         dps->dp_out, pulse frame_valid for exactly 1 cycle, clear seen. Repeat capture of a digit
//         already seen overwrites its shadow value (latest wins), no error.
//  Latency: from sseg/an change to frame_valid = SETTLE+3 cycles for the last digit of a frame.
//  Timeout counter: 0 on reset/frame_valid, increments otherwise, saturates at TIMEOUT;
//   timeout = (count==TIMEOUT). Cleared the same cycle frame_valid pulses.
//  digit_err/scan_err clear only on reset. hex*/dp_out hold between frames.
//  Glitch shorter than SETTLE cycles: never sampled; dwell returns to WAIT and restarts settling.
// TESTING
//  1 Drive an=1110/sseg=8'hFF-0x01 style: digits 0,1,2,3 = codes 4F,12,06,4C (dp off), each 20 cycles
//    -> one frame_valid; hex0=1 hex1=2 hex2=3 hex3=4, dp_out=0000, no errors.
//  2 Same scan with sseg[7]=0 on an=1011 only, digit pattern 08 -> hex2=A, dp_out=0100.
//  3 Dwell shorter than SETTLE (2 cycles) inserted between digits -> not captured, frame unchanged,
//    next full frame decodes correctly.
//  4 Pattern 7F on digit1 -> digit_err=1 (sticky), hex1=0 on that frame; an=1100 held 10 cycles -> scan_err=1.
//  5 No scan (an=1111) for TIMEOUT cycles (use TIMEOUT=64) -> timeout rises at cycle 64,
//    falls with next frame_valid.
//  6 Assert reset after 2 digits captured -> all outputs 0; next 4 digits form a fresh frame.

Source files
------------

// File: rtl/disp_hex_demux.sv
// Receive-side decoder for the multiplexed 4-digit 7-seg bus: waits for each digit dwell to settle,
// decodes the active-low segment pattern to a nibble and publishes complete 4-digit frames.
module disp_hex_demux #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [7:0] sseg,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] dp_out,
    output logic       frame_valid,
    output logic       digit_err,
    output logic       scan_err,
    output logic       timeout
);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {WAIT, SAMPLE, HOLD} state_t;

    state_t          state, state_d;
    logic [3:0]      an_q;
    logic [7:0]      sseg_q;
    logic [SW-1:0]   stab;
    logic [TW-1:0]   tcnt;
    logic [3:0][3:0] shadow;
    logic [3:0]      dps;
    logic [3:0]      seen;
    logic            pend;

    logic       chg, settled, onehot, blank, capture, scan_set;
    logic [1:0] idx;
    logic [4:0] dec;

    // Returns {valid, nibble}; unknown patterns decode to 0 with valid low.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h01: decode = 5'h10;  7'h4F: decode = 5'h11;
            7'h12: decode = 5'h12;  7'h06: decode = 5'h13;
            7'h4C: decode = 5'h14;  7'h24: decode = 5'h15;
            7'h20: decode = 5'h16;  7'h0F: decode = 5'h17;
            7'h00: decode = 5'h18;  7'h04: decode = 5'h19;
            7'h08: decode = 5'h1A;  7'h60: decode = 5'h1B;
            7'h31: decode = 5'h1C;  7'h42: decode = 5'h1D;
            7'h30: decode = 5'h1E;  7'h38: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign chg     = ({an, sseg} != {an_q, sseg_q});
    assign settled = (stab >= SW'(SETTLE - 1));
    assign blank   = (an_q == 4'b1111);
    assign dec     = decode(sseg_q[6:0]);
    assign timeout = (tcnt == TW'(TIMEOUT));

    always_comb begin
        onehot = 1'b1;
        idx    = 2'd0;
        case (an_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: onehot = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state;
        capture  = 1'b0;
        scan_set = 1'b0;
        case (state)
            WAIT: begin
                if (settled) begin
                    if (onehot)      state_d  = SAMPLE;
                    else if (!blank) scan_set = 1'b1;
                end
            end
            SAMPLE: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            // stab==0 also catches a change that landed during the SAMPLE cycle
            HOLD: if (chg || stab == '0) state_d = WAIT;
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WAIT;
            an_q        <= 4'b1111;
            sseg_q      <= 8'hFF;
            stab        <= '0;
            tcnt        <= '0;
            shadow      <= '0;
            dps         <= '0;
            seen        <= '0;
            pend        <= 1'b0;
            hex3        <= '0;
            hex2        <= '0;
            hex1        <= '0;
            hex0        <= '0;
            dp_out      <= '0;
            frame_valid <= 1'b0;
            digit_err   <= 1'b0;
            scan_err    <= 1'b0;
        end else begin
            state       <= state_d;
            an_q        <= an;
            sseg_q      <= sseg;
            frame_valid <= pend;
            pend        <= 1'b0;

            if (chg)                      stab <= '0;
            else if (stab != SW'(SETTLE)) stab <= stab + SW'(1);

            if (pend)                        tcnt <= '0;
            else if (tcnt != TW'(TIMEOUT))   tcnt <= tcnt + TW'(1);

            if (scan_set) scan_err <= 1'b1;

            if (capture) begin
                shadow[idx] <= dec[3:0];
                dps[idx]    <= ~sseg_q[7];
                seen        <= seen | ~an_q;
                if (!dec[4]) digit_err <= 1'b1;
                if ((seen | ~an_q) == 4'b1111) pend <= 1'b1;
            end

            // Publish one cycle after the frame completes
            if (pend) begin
                hex0   <= shadow[0];
                hex1   <= shadow[1];
                hex2   <= shadow[2];
                hex3   <= shadow[3];
                dp_out <= dps;
                seen   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_disp_hex_demux.sv
// Directed bench for disp_hex_demux: stimulus pushes expected frames, a negedge monitor pops and checks.
module tb_disp_hex_demux;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [3:0] h0, h1, h2, h3, dp;
        logic       derr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] an;
    logic [7:0] sseg;
    logic [3:0] hex3, hex2, hex1, hex0, dp_out;
    logic       frame_valid, digit_err, scan_err, timeout;

    exp_t q[$];
    int   total = 0, bad = 0, cyc = 0, last_t = 0, nframes = 0, npush = 0;

    disp_hex_demux #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(rst), .an(an), .sseg(sseg),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0), .dp_out(dp_out),
        .frame_valid(frame_valid), .digit_err(digit_err), .scan_err(scan_err), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] h0, h1, h2, h3, dp, input logic derr);
        exp_t e;
        e.h0 = h0; e.h1 = h1; e.h2 = h2; e.h3 = h3; e.dp = dp; e.derr = derr;
        q.push_back(e);
        npush++;
    endtask

    // Light digit i with a 7-bit pattern for n cycles; called on a negedge
    task automatic dig(input int i, input logic [6:0] code, input logic dp, input int n);
        logic [3:0] one = 4'b0001;
        an     = ~(one << i);
        sseg   = {~dp, code};
        last_t = cyc;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        an   = 4'b1111;
        sseg = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && frame_valid) begin
            nframes++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got frame_valid with empty queue (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("hex0", hex0, e.h0);
                chk("hex1", hex1, e.h1);
                chk("hex2", hex2, e.h2);
                chk("hex3", hex3, e.h3);
                chk("dp_out", dp_out, e.dp);
                chk("digit_err", digit_err, e.derr);
                chk("timeout_at_frame", timeout, 0);
                chk("latency", cyc - last_t, SETTLE + 3);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        an   = 4'b1111;
        sseg = 8'hFF;
        repeat (3) @(negedge clk);
        chk("reset_outs", {hex3, hex2, hex1, hex0, dp_out, frame_valid, digit_err, scan_err, timeout}, 0);
        rst = 1'b0;

        // Blank bus: timeout rises exactly at cycle TIMEOUT
        repeat (TIMEOUT - 1) @(negedge clk);
        chk("timeout_pre", timeout, 0);
        @(negedge clk);
        chk("timeout_rise", timeout, 1);
        chk("scan_err_blank", scan_err, 0);

        // Basic frame 1,2,3,4
        push(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, 1'b0);
        dig(0, 7'h4F, 0, 20); dig(1, 7'h12, 0, 20); dig(2, 7'h06, 0, 20); dig(3, 7'h4C, 0, 20);

        // dp on digit 2 with pattern A
        push(4'h1, 4'h2, 4'hA, 4'h4, 4'b0100, 1'b0);
        dig(0, 7'h4F, 0, 20); dig(1, 7'h12, 0, 20); dig(2, 7'h08, 1, 20); dig(3, 7'h4C, 0, 20);

        // Remaining decode codes 0,7,9,B
        push(4'h0, 4'h7, 4'h9, 4'hB, 4'b0000, 1'b0);
        dig(0, 7'h01, 0, 20); dig(1, 7'h0F, 0, 20); dig(2, 7'h04, 0, 20); dig(3, 7'h60, 0, 20);

        // Short glitch dwells must never be captured
        push(4'h5, 4'h6, 4'h8, 4'hC, 4'b0000, 1'b0);
        dig(0, 7'h24, 0, 20); dig(1, 7'h20, 0, 20);
        dig(2, 7'h0F, 0, 2);  dig(3, 7'h01, 0, 2);
        dig(2, 7'h00, 0, 20); dig(3, 7'h31, 0, 20);
        idle(20);
        chk("frames_after_glitch", nframes, 4);

        // Invalid pattern on digit 1, then an illegal anode pattern
        push(4'hD, 4'h0, 4'hE, 4'hF, 4'b0000, 1'b1);
        dig(0, 7'h42, 0, 20); dig(1, 7'h7F, 0, 20); dig(2, 7'h30, 0, 20); dig(3, 7'h38, 0, 20);
        idle(20);
        chk("scan_err_pre", scan_err, 0);
        an   = 4'b1100;
        sseg = 8'h81;
        repeat (10) @(negedge clk);
        chk("scan_err_set", scan_err, 1);
        idle(10);
        chk("scan_err_sticky", scan_err, 1);
        chk("digit_err_sticky", digit_err, 1);

        // Async reset after two captured digits, then a fresh frame in a different order
        dig(0, 7'h01, 0, 20); dig(1, 7'h4F, 0, 20);
        rst  = 1'b1;
        an   = 4'b1111;
        sseg = 8'hFF;
        #1;
        chk("midframe_reset_outs", {hex3, hex2, hex1, hex0, dp_out, frame_valid, digit_err, scan_err, timeout}, 0);
        @(negedge clk);
        rst = 1'b0;
        push(4'h4, 4'h5, 4'h2, 4'h3, 4'b0001, 1'b0);
        dig(2, 7'h12, 0, 20); dig(3, 7'h06, 0, 20); dig(0, 7'h4C, 1, 20); dig(1, 7'h24, 0, 20);
        idle(20);
        chk("scan_err_after_reset", scan_err, 0);

        chk("queue_empty", q.size(), 0);
        chk("frame_count", nframes, npush);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
